// File: rtl/dut_stream_bridge_pkg.sv
// Shared types and widths for the DMA <-> DUT stream bridge.
package dut_bridge_pkg;

  typedef enum logic {
    MODE_FREE_RUN = 1'b0,
    MODE_LOSSLESS = 1'b1
  } mode_e;

  localparam int unsigned STAT_W    = 32;
  localparam int unsigned PKT_LEN_W = 16;

endpackage

// File: rtl/dut_stream_bridge_sfifo_sync.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted
// only when a pop happens in the same cycle.
module sfifo_sync #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (AW+1)'(DEPTH));
    count   = count_q;
    dout    = mem_q[rd_ptr_q];
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dut_stream_bridge.sv
// AXI-Stream harness: source -> fixed-latency DUT -> FIFO -> sink + testvec streams,
// with drop-on-full or credit-based flow control, packet framing and statistics.
module dut_stream_bridge
  import dut_bridge_pkg::*;
#(
  parameter int unsigned DIN_W      = 16,
  parameter int unsigned DOUT_W     = 16,
  parameter int unsigned AXIS_W     = 32,
  parameter int unsigned TV_W       = 64,
  parameter int unsigned DUT_LAT    = 8,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_en,
  input  logic                  cfg_mode,
  input  logic [PKT_LEN_W-1:0]  cfg_pkt_len,
  input  logic [AXIS_W-1:0]     s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DIN_W-1:0]      dut_din,
  output logic                  dut_vld,
  input  logic [DOUT_W-1:0]     dut_dout,
  input  logic [TV_W-1:0]       dut_tv,
  output logic [AXIS_W-1:0]     m_tdata,
  output logic [AXIS_W/8-1:0]   m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [TV_W-1:0]       t_tdata,
  output logic [TV_W/8-1:0]     t_tkeep,
  output logic                  t_tlast,
  output logic                  t_tvalid,
  input  logic                  t_tready,
  output logic [STAT_W-1:0]     stat_drop_cnt,
  output logic [STAT_W-1:0]     stat_pkt_cnt,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = TV_W + DOUT_W;

  logic [DUT_LAT-1:0]   vld_dly_q, vld_dly_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic                 taken_m_q, taken_m_d;
  logic                 taken_t_q, taken_t_d;
  logic [PKT_LEN_W-1:0] beat_q, beat_d;
  logic [STAT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [STAT_W-1:0]    pkt_cnt_q, pkt_cnt_d;

  logic                 push, pop;
  logic                 fifo_empty, fifo_full;
  logic [CNT_W-1:0]     fifo_count;
  logic [ENT_W-1:0]     fifo_dout;
  logic [CNT_W:0]       occupancy;
  logic                 credit_ok;
  logic                 hs_m, hs_t, served_m, served_t;
  logic                 last_beat;

  if (AXIS_W > DIN_W) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^s_tdata[AXIS_W-1:DIN_W];
  end

  sfifo_sync #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({dut_tv, dut_dout}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Credits count FIFO entries plus samples still inside the DUT pipeline.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {1'b0, inflight_q};
    credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);
    s_tready  = ~rst & cfg_en & ((mode_e'(cfg_mode) == MODE_FREE_RUN) | credit_ok);
    dut_vld   = s_tvalid & s_tready;
    dut_din   = s_tdata[DIN_W-1:0];
    push      = vld_dly_q[DUT_LAT-1];

    m_tvalid  = ~fifo_empty & ~taken_m_q;
    t_tvalid  = ~fifo_empty & ~taken_t_q;
    hs_m      = m_tvalid & m_tready;
    hs_t      = t_tvalid & t_tready;
    served_m  = taken_m_q | hs_m;
    served_t  = taken_t_q | hs_t;
    pop       = ~fifo_empty & served_m & served_t;

    last_beat = (cfg_pkt_len != '0) && (beat_q == cfg_pkt_len - PKT_LEN_W'(1));
    m_tlast   = ~fifo_empty & last_beat;
    t_tlast   = ~fifo_empty & last_beat;
    m_tdata   = AXIS_W'($signed(fifo_dout[DOUT_W-1:0]));
    t_tdata   = fifo_dout[ENT_W-1:DOUT_W];
    m_tkeep   = '1;
    t_tkeep   = '1;

    busy          = (inflight_q != '0) | ~fifo_empty;
    stat_drop_cnt = drop_cnt_q;
    stat_pkt_cnt  = pkt_cnt_q;
  end

  always_comb begin
    vld_dly_d    = vld_dly_q;
    vld_dly_d[0] = dut_vld;
    for (int unsigned i = 1; i < DUT_LAT; i++) vld_dly_d[i] = vld_dly_q[i-1];

    case ({dut_vld, push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    taken_m_d = pop ? 1'b0 : served_m;
    taken_t_d = pop ? 1'b0 : served_t;

    // An idle, disabled bridge closes any partial packet.
    beat_d = beat_q;
    if (pop)                 beat_d = last_beat ? '0 : beat_q + PKT_LEN_W'(1);
    else if (~cfg_en & ~busy) beat_d = '0;

    pkt_cnt_d = pkt_cnt_q;
    if (pop & last_beat) pkt_cnt_d = pkt_cnt_q + STAT_W'(1);

    drop_cnt_d = drop_cnt_q;
    if (push & fifo_full & ~pop & (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_dly_q  <= '0;
      inflight_q <= '0;
      taken_m_q  <= 1'b0;
      taken_t_q  <= 1'b0;
      beat_q     <= '0;
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      vld_dly_q  <= vld_dly_d;
      inflight_q <= inflight_d;
      taken_m_q  <= taken_m_d;
      taken_t_q  <= taken_t_d;
      beat_q     <= beat_d;
      drop_cnt_q <= drop_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_dut_stream_bridge.sv
// Directed bench for dut_stream_bridge with an identity DUT of latency LAT.
module tb_dut_stream_bridge;

  localparam int unsigned LAT = 8;

  logic        clk, rst, cfg_en, cfg_mode;
  logic [15:0] cfg_pkt_len;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [15:0] dut_din, dut_dout;
  logic        dut_vld;
  logic [63:0] dut_tv;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready;
  logic [63:0] t_tdata;
  logic [7:0]  t_tkeep;
  logic        t_tlast, t_tvalid, t_tready;
  logic [31:0] stat_drop_cnt, stat_pkt_cnt;
  logic        busy;

  dut_stream_bridge #(
    .DIN_W(16), .DOUT_W(16), .AXIS_W(32), .TV_W(64), .DUT_LAT(LAT), .FIFO_DEPTH(64)
  ) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_pkt_len(cfg_pkt_len),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .dut_din(dut_din), .dut_vld(dut_vld), .dut_dout(dut_dout), .dut_tv(dut_tv),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .t_tdata(t_tdata), .t_tkeep(t_tkeep), .t_tlast(t_tlast), .t_tvalid(t_tvalid), .t_tready(t_tready),
    .stat_drop_cnt(stat_drop_cnt), .stat_pkt_cnt(stat_pkt_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Identity DUT: din presented in cycle 0 appears on dout in cycle LAT.
  logic [15:0] pipe_q [LAT];
  always @(posedge clk) begin
    pipe_q[0] <= dut_din;
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign dut_dout = pipe_q[LAT-1];
  assign dut_tv   = {48'hC0FF_EE00_0000, pipe_q[LAT-1]};

  int unsigned n_err = 0, n_checks = 0;
  int unsigned sent, send_lim, m_idx, t_idx, cur_pkt_len, lat;
  logic [31:0] data_base, first_m;
  logic        m_rdy, t_rdy;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_last(input int unsigned i);
    return (cur_pkt_len != 0) && ((i % cur_pkt_len) == cur_pkt_len - 1);
  endfunction

  task automatic clear_model();
    exp_q.delete();
    sent = 0; m_idx = 0; t_idx = 0; send_lim = 0;
  endtask

  task automatic run(input int unsigned ncyc);
    logic [15:0] d;
    for (int unsigned c = 0; c < ncyc; c++) begin
      @(negedge clk);
      s_tvalid = (sent < send_lim);
      s_tdata  = data_base + sent;
      m_tready = m_rdy;
      t_tready = t_rdy;
      #1;
      if (s_tvalid && s_tready) begin
        exp_q.push_back(s_tdata[15:0]);
        sent++;
      end
      if (m_tvalid && m_tready) begin
        if (m_idx >= exp_q.size()) chk("m_extra_beat", 64'(m_idx), 64'(exp_q.size()));
        else begin
          d = exp_q[m_idx];
          chk("m_tdata", 64'(m_tdata), 64'({{16{d[15]}}, d}));
          chk("m_tlast", 64'(m_tlast), 64'(exp_last(m_idx)));
          if (m_idx == 0) first_m = m_tdata;
        end
        m_idx++;
      end
      if (t_tvalid && t_tready) begin
        if (t_idx >= exp_q.size()) chk("t_extra_beat", 64'(t_idx), 64'(exp_q.size()));
        else begin
          d = exp_q[t_idx];
          chk("t_tdata", t_tdata, {48'hC0FF_EE00_0000, d});
          chk("t_tlast", 64'(t_tlast), 64'(exp_last(t_idx)));
        end
        t_idx++;
      end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b1; cfg_mode = 1'b1; cfg_pkt_len = 16'd0;
    s_tdata = '0; s_tvalid = 1'b1; m_tready = 1'b0; t_tready = 1'b0;
    m_rdy = 1'b0; t_rdy = 1'b0; data_base = 32'd1; first_m = '0; cur_pkt_len = 0; lat = 0;
    clear_model();

    // Reset state, with cfg_en and s_tvalid held high
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_dut_vld", 64'(dut_vld), 64'(0));
    @(negedge clk);
    rst = 1'b0; s_tvalid = 1'b0;
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_t_tvalid", 64'(t_tvalid), 64'(0));
    chk("rst_tlast", 64'({m_tlast, t_tlast}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stats", {stat_drop_cnt, stat_pkt_cnt}, 64'(0));

    // 1: LOSSLESS, pkt_len=4, 8 samples 1..8
    cur_pkt_len = 4; cfg_pkt_len = 16'd4; cfg_mode = 1'b1;
    clear_model(); data_base = 32'd1; send_lim = 8; m_rdy = 1'b1; t_rdy = 1'b1;
    run(30);
    chk("t1_m_beats", 64'(m_idx), 64'(8));
    chk("t1_t_beats", 64'(t_idx), 64'(8));
    chk("t1_pkt_cnt", 64'(stat_pkt_cnt), 64'(2));
    chk("t1_tkeep", 64'({m_tkeep, t_tkeep}), 64'(12'hFFF));
    chk("t1_busy", 64'(busy), 64'(0));

    // 2: LOSSLESS credit stop at FIFO_DEPTH issues
    cur_pkt_len = 16; cfg_pkt_len = 16'd16;
    clear_model(); send_lim = 1000; m_rdy = 1'b0; t_rdy = 1'b1;
    run(90);
    chk("t2_issued", 64'(sent), 64'(64));
    s_tvalid = 1'b1;
    #1;
    chk("t2_s_tready_low", 64'(s_tready), 64'(0));
    send_lim = sent; m_rdy = 1'b1;
    run(100);
    chk("t2_m_beats", 64'(m_idx), 64'(64));
    chk("t2_t_beats", 64'(t_idx), 64'(64));
    chk("t2_drop", 64'(stat_drop_cnt), 64'(0));
    chk("t2_pkt_cnt", 64'(stat_pkt_cnt), 64'(6));
    chk("t2_busy", 64'(busy), 64'(0));

    // 3: FREE_RUN with stalled sinks, 100 samples
    cur_pkt_len = 0; cfg_pkt_len = 16'd0; cfg_mode = 1'b0;
    clear_model(); send_lim = 100; m_rdy = 1'b0; t_rdy = 1'b0;
    run(115);
    chk("t3_issued", 64'(sent), 64'(100));
    chk("t3_drop", 64'(stat_drop_cnt), 64'(36));
    chk("t3_m_tvalid", 64'(m_tvalid), 64'(1));
    m_rdy = 1'b1; t_rdy = 1'b1;
    run(90);
    chk("t3_m_beats", 64'(m_idx), 64'(64));
    chk("t3_t_beats", 64'(t_idx), 64'(64));
    chk("t3_drop_after", 64'(stat_drop_cnt), 64'(36));
    chk("t3_busy", 64'(busy), 64'(0));

    // 4: independent readies
    cfg_mode = 1'b1;
    clear_model(); data_base = 32'd500; send_lim = 3; m_rdy = 1'b1; t_rdy = 1'b0;
    run(22);
    chk("t4_m_one_beat", 64'(m_idx), 64'(1));
    chk("t4_m_tvalid_wait", 64'(m_tvalid), 64'(0));
    chk("t4_t_tvalid", 64'(t_tvalid), 64'(1));
    chk("t4_busy", 64'(busy), 64'(1));
    t_rdy = 1'b1;
    run(12);
    chk("t4_m_beats", 64'(m_idx), 64'(3));
    chk("t4_t_beats", 64'(t_idx), 64'(3));
    chk("t4_busy_end", 64'(busy), 64'(0));

    // 5: sign extension, pkt_len=0
    clear_model(); data_base = 32'h0000_8001; send_lim = 2; m_rdy = 1'b1; t_rdy = 1'b1;
    run(20);
    chk("t5_sext", 64'(first_m), 64'(32'hFFFF_8001));
    chk("t5_m_beats", 64'(m_idx), 64'(2));
    chk("t5_pkt_cnt", 64'(stat_pkt_cnt), 64'(6));

    // 6: reset mid-stream with FIFO about half full
    clear_model(); data_base = 32'd1000; send_lim = 40; m_rdy = 1'b0; t_rdy = 1'b0;
    run(45);
    chk("t6_busy_pre", 64'(busy), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_valids", 64'({m_tvalid, t_tvalid}), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_stats", {stat_drop_cnt, stat_pkt_cnt}, 64'(0));
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = 32'h0000_1234; m_tready = 1'b1; t_tready = 1'b1;
    #1;
    chk("t6_issue", 64'({dut_vld, dut_din}), 64'(17'h1_1234));
    lat = 0;
    for (int unsigned n = 1; n <= 30; n++) begin
      @(negedge clk);
      s_tvalid = 1'b0;
      #1;
      if (m_tvalid && lat == 0) begin
        lat = n;
        chk("t6_data", 64'(m_tdata), 64'(32'h0000_1234));
      end
    end
    chk("t6_latency", 64'(lat), 64'(LAT + 1));
    chk("t6_busy_end", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
